// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, tag check, bulk flush and perf counters.
// Lookup is combinational with zero latency; updates, flushes and perf counting take effect on the next CLK edge.
module otter_branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int TAG_BITS  = 8,
  parameter int PERF_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 LKP_VALID,
  input  logic [31:0]          LKP_PC,
  output logic                 PRED_HIT,
  output logic                 PRED_TAKEN,
  output logic [31:0]          PRED_TARGET,
  input  logic                 UPD_VALID,
  input  logic [31:0]          UPD_PC,
  input  logic                 UPD_IS_JUMP,
  input  logic                 UPD_TAKEN,
  input  logic [31:0]          UPD_TARGET,
  input  logic                 UPD_MISPRED,
  input  logic                 FLUSH,
  input  logic                 PERF_CLR,
  output logic [PERF_BITS-1:0] PERF_LOOKUPS,
  output logic [PERF_BITS-1:0] PERF_MISPREDS
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
  logic [31:0]         tgt_q   [ENTRIES];

  logic [IDX-1:0]      lkp_idx;
  logic [TAG_BITS-1:0] lkp_tag;
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_nxt;
  logic                wr_ctr;
  logic                wr_tgt;
  logic                alloc;
  logic                unused_pc_bits;

  assign lkp_idx = LKP_PC[IDX+1:2];
  assign lkp_tag = LKP_PC[IDX+1+TAG_BITS:IDX+2];
  assign upd_idx = UPD_PC[IDX+1:2];
  assign upd_tag = UPD_PC[IDX+1+TAG_BITS:IDX+2];
  assign unused_pc_bits = ^{LKP_PC, UPD_PC};

  // Lookup reads the pre-update array; no bypass from a same-cycle write.
  assign PRED_HIT    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign PRED_TAKEN  = PRED_HIT && ctr_q[lkp_idx][CTR_BITS-1];
  assign PRED_TARGET = PRED_HIT ? tgt_q[lkp_idx] : 32'd0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign ctr_cur = ctr_q[upd_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    wr_ctr  = 1'b0;
    wr_tgt  = 1'b0;
    alloc   = 1'b0;
    if (UPD_VALID && !FLUSH) begin
      if (upd_hit) begin
        wr_ctr = 1'b1;
        if (UPD_IS_JUMP) begin
          ctr_nxt = CTR_MAX;
          wr_tgt  = 1'b1;
        end else if (UPD_TAKEN) begin
          ctr_nxt = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_BITS'(1);
          wr_tgt  = 1'b1;
        end else begin
          ctr_nxt = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_BITS'(1);
        end
      end else if (UPD_TAKEN) begin
        // Taken miss evicts whatever entry aliases this index.
        alloc   = 1'b1;
        wr_ctr  = 1'b1;
        wr_tgt  = 1'b1;
        ctr_nxt = UPD_IS_JUMP ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        tgt_q[i]   <= '0;
      end
    end else begin
      if (FLUSH) begin
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (alloc) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
      end
      if (wr_ctr) ctr_q[upd_idx] <= ctr_nxt;
      if (wr_tgt) tgt_q[upd_idx] <= UPD_TARGET;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PERF_LOOKUPS  <= '0;
      PERF_MISPREDS <= '0;
    end else if (PERF_CLR) begin
      PERF_LOOKUPS  <= '0;
      PERF_MISPREDS <= '0;
    end else begin
      if (LKP_VALID)               PERF_LOOKUPS  <= PERF_LOOKUPS + PERF_BITS'(1);
      if (UPD_VALID && UPD_MISPRED) PERF_MISPREDS <= PERF_MISPREDS + PERF_BITS'(1);
    end
  end

endmodule
